// File: rtl/vga_scan_if.sv
// Signal bundle between the raster controller (slave) and its drawing/DAC environment (master).
interface vga_scan_if;
   logic        pix_ce;
   logic        run;
   logic [7:0]  colorR;
   logic [7:0]  colorG;
   logic [7:0]  colorB;
   logic [9:0]  xPixel;
   logic [8:0]  yPixel;
   logic [7:0]  VGAr;
   logic [7:0]  VGAg;
   logic [7:0]  VGAb;
   logic        VGAhs;
   logic        VGAvs;
   logic        VGAblank_n;
   logic        frameStart;
   logic [15:0] frameCount;
   logic        busy;

   modport master (
      output pix_ce, run, colorR, colorG, colorB,
      input  xPixel, yPixel, VGAr, VGAg, VGAb, VGAhs, VGAvs, VGAblank_n,
             frameStart, frameCount, busy
   );

   modport slave (
      input  pix_ce, run, colorR, colorG, colorB,
      output xPixel, yPixel, VGAr, VGAg, VGAb, VGAhs, VGAvs, VGAblank_n,
             frameStart, frameCount, busy
   );
endinterface

// File: rtl/vga_scan_controller.sv
// 640x480@60 raster sequencer with run/stop control and a one-pix_ce colour/sync pipeline.
// Optional macro TEST_PATTERN_EN replaces the colour inputs with an 8-bar test pattern.
module vga_scan_controller #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic      clk,
   input  logic      rst_n,
   vga_scan_if.slave bus
);
   localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_ON  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_ON  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t      state_r;
   state_t      state_nx_s;
   logic [9:0]  h_cnt_r;
   logic [9:0]  v_cnt_r;
   logic [9:0]  h_nx_s;
   logic [9:0]  v_nx_s;
   logic [9:0]  x_pix_r;
   logic [8:0]  y_pix_r;
   logic [7:0]  vga_r_r;
   logic [7:0]  vga_g_r;
   logic [7:0]  vga_b_r;
   logic        hs_r;
   logic        vs_r;
   logic        blank_n_r;
   logic        frame_start_r;
   logic [15:0] frame_cnt_r;
   logic        busy_r;

   logic        scan_s;
   logic        frame_end_s;
   logic        act_s;
   logic        act_nx_s;
   logic        hs_act_s;
   logic        vs_act_s;
   logic        frame_start_s;
   logic        frame_wrap_s;
   logic [7:0]  pix_r_s;
   logic [7:0]  pix_g_s;
   logic [7:0]  pix_b_s;

`ifdef TEST_PATTERN_EN
   function automatic logic [2:0] bar_index(input logic [9:0] x);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 1; i < 8; i++) begin
         idx = (x >= 10'(80 * i)) ? 3'(i) : idx;
      end
      return idx;
   endfunction

   logic [2:0] bar_s;

   // Vertical colour bars keyed off the presented column.
   always_comb begin
      bar_s   = bar_index(x_pix_r);
      pix_r_s = {8{bar_s[2]}};
      pix_g_s = {8{bar_s[1]}};
      pix_b_s = {8{bar_s[0]}};
   end
`else
   // Colour comes straight from the drawing logic for the presented pixel.
   always_comb begin
      pix_r_s = bus.colorR;
      pix_g_s = bus.colorG;
      pix_b_s = bus.colorB;
   end
`endif

   // Next-state and next-counter decode; "presented" means the pixel currently on xPixel/yPixel.
   always_comb begin
      state_nx_s  = state_r;
      h_nx_s      = h_cnt_r;
      v_nx_s      = v_cnt_r;
      scan_s      = (state_r != ST_IDLE);
      frame_end_s = (h_cnt_r == H_LAST) && (v_cnt_r == V_LAST);
      case (state_r)
         ST_IDLE: begin
            h_nx_s = 10'd0;
            v_nx_s = 10'd0;
            if (bus.run) begin
               state_nx_s = ST_RUN;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RUN, ST_DRAIN: begin
            if (h_cnt_r == H_LAST) begin
               h_nx_s = 10'd0;
               if (v_cnt_r == V_LAST) begin
                  v_nx_s = 10'd0;
               end else begin
                  v_nx_s = v_cnt_r + 10'd1;
               end
            end else begin
               h_nx_s = h_cnt_r + 10'd1;
            end
            // run wins even on the frame-end pixel, so a late restart never drops to IDLE
            if (bus.run) begin
               state_nx_s = ST_RUN;
            end else if ((state_r == ST_DRAIN) && frame_end_s) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_DRAIN;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            h_nx_s     = 10'd0;
            v_nx_s     = 10'd0;
         end
      endcase
      act_s         = scan_s && (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);
      hs_act_s      = scan_s && (h_cnt_r >= HS_ON) && (h_cnt_r < HS_OFF);
      vs_act_s      = scan_s && (v_cnt_r >= VS_ON) && (v_cnt_r < VS_OFF);
      act_nx_s      = (state_nx_s != ST_IDLE) && (h_nx_s < H_VIS) && (v_nx_s < V_VIS);
      frame_start_s = (state_nx_s != ST_IDLE) && (!scan_s || frame_end_s);
      frame_wrap_s  = scan_s && frame_end_s;
   end

   // Raster state, presented-pixel coordinates and the aligned colour/sync output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         h_cnt_r       <= 10'd0;
         v_cnt_r       <= 10'd0;
         x_pix_r       <= 10'd0;
         y_pix_r       <= 9'd0;
         vga_r_r       <= 8'd0;
         vga_g_r       <= 8'd0;
         vga_b_r       <= 8'd0;
         hs_r          <= ~SYNC_POL;
         vs_r          <= ~SYNC_POL;
         blank_n_r     <= 1'b0;
         frame_start_r <= 1'b0;
         frame_cnt_r   <= 16'd0;
         busy_r        <= 1'b0;
      end else if (bus.pix_ce) begin
         state_r       <= state_nx_s;
         h_cnt_r       <= h_nx_s;
         v_cnt_r       <= v_nx_s;
         x_pix_r       <= act_nx_s ? h_nx_s : 10'd0;
         y_pix_r       <= act_nx_s ? v_nx_s[8:0] : 9'd0;
         vga_r_r       <= act_s ? pix_r_s : 8'd0;
         vga_g_r       <= act_s ? pix_g_s : 8'd0;
         vga_b_r       <= act_s ? pix_b_s : 8'd0;
         hs_r          <= hs_act_s ? SYNC_POL : ~SYNC_POL;
         vs_r          <= vs_act_s ? SYNC_POL : ~SYNC_POL;
         blank_n_r     <= act_s;
         frame_start_r <= frame_start_s;
         busy_r        <= (state_nx_s != ST_IDLE);
         if (frame_wrap_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
         end
      end else begin
         frame_start_r <= 1'b0;
      end
   end

   assign bus.xPixel     = x_pix_r;
   assign bus.yPixel     = y_pix_r;
   assign bus.VGAr       = vga_r_r;
   assign bus.VGAg       = vga_g_r;
   assign bus.VGAb       = vga_b_r;
   assign bus.VGAhs      = hs_r;
   assign bus.VGAvs      = vs_r;
   assign bus.VGAblank_n = blank_n_r;
   assign bus.frameStart = frame_start_r;
   assign bus.frameCount = frame_cnt_r;
   assign bus.busy       = busy_r;
endmodule
